// File: rtl/fc_row_engine.sv
// rtl/fc_row_engine.sv - fully connected layer row engine
// One signed Q16.16 dot product per weight row, emitted with saturation to 32 bits.
module fc_row_engine #(
   parameter int NUM_ROWS = 10,
   parameter int VEC_LEN  = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [32*VEC_LEN-1:0] i_input_vec,
   output logic [6:0]            o_address,
   input  logic [32*VEC_LEN-1:0] i_weights,
   output logic                  o_out_valid,
   output logic [6:0]            o_out_index,
   output logic [31:0]           o_out_value,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam logic [6:0] LAST_ROW = 7'(NUM_ROWS - 1);
   localparam logic [4:0] LAST_J   = 5'(VEC_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_MAC,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                r_state;
   logic [32*VEC_LEN-1:0] r_vec;
   logic [6:0]            r_row;
   logic [4:0]            r_j;
   logic signed [69:0]    r_acc;

   logic signed [31:0]    w_x;
   logic signed [31:0]    w_w;
   logic signed [63:0]    w_prod;
   logic signed [69:0]    w_acc_next;
   logic signed [69:0]    w_shift;
   logic [31:0]           w_sat;

   assign w_x        = r_vec[{r_j, 5'd0} +: 32];
   assign w_w        = i_weights[{r_j, 5'd0} +: 32];
   assign w_prod     = $signed({{32{w_x[31]}}, w_x}) * $signed({{32{w_w[31]}}, w_w});
   assign w_acc_next = r_acc + $signed({{6{w_prod[63]}}, w_prod});
   assign w_shift    = w_acc_next >>> 16;

   // In range only when bits 69..31 are a pure sign extension.
   always_comb begin
      w_sat = w_shift[31:0];
      if (!((&w_shift[69:31]) || !(|w_shift[69:31]))) begin
         w_sat = w_shift[69] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_row       <= '0;
         r_j         <= '0;
         r_acc       <= '0;
         o_address   <= '0;
         o_out_valid <= 1'b0;
         o_out_index <= '0;
         o_out_value <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         o_out_valid <= 1'b0;
         o_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_vec     <= i_input_vec;
                  o_address <= '0;
                  r_row     <= '0;
                  r_acc     <= '0;
                  o_busy    <= 1'b1;
                  r_state   <= S_FETCH;
               end
            end
            S_FETCH: begin
               r_acc   <= '0;
               r_j     <= '0;
               r_state <= S_MAC;
            end
            S_MAC: begin
               r_acc <= w_acc_next;
               r_j   <= r_j + 5'd1;
               // Result is registered on the last MAC edge so the strobe lands in the EMIT cycle.
               if (r_j == LAST_J) begin
                  o_out_value <= w_sat;
                  o_out_index <= r_row;
                  o_out_valid <= 1'b1;
                  r_state     <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (r_row == LAST_ROW) begin
                  o_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  o_address <= r_row + 7'd1;
                  r_row     <= r_row + 7'd1;
                  r_state   <= S_FETCH;
               end
            end
            S_DONE: begin
               o_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_row_engine.sv
// tb/tb_fc_row_engine.sv - directed self-checking bench for fc_row_engine
// Two instances: NUM_ROWS=10 and NUM_ROWS=1, each fed by a registered weight memory.
module tb_fc_row_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset1, start1, reset2, start2;
   logic [1023:0] vec1, vec2, w1, w2;
   logic [6:0]    addr1, addr2, idx1, idx2;
   logic          v1, v2, busy1, busy2, done1, done2;
   logic [31:0]   val1, val2;

   logic [1023:0] mem1 [10];
   logic [1023:0] mem2;
   logic [31:0]   exp_v [10];

   int checks = 0;
   int errors = 0;
   logic sel = 1'b0;

   fc_row_engine #(.NUM_ROWS(10)) dut1 (
      .i_clk(clk), .i_reset(reset1), .i_start(start1), .i_input_vec(vec1),
      .o_address(addr1), .i_weights(w1), .o_out_valid(v1), .o_out_index(idx1),
      .o_out_value(val1), .o_busy(busy1), .o_done(done1));

   fc_row_engine #(.NUM_ROWS(1)) dut2 (
      .i_clk(clk), .i_reset(reset2), .i_start(start2), .i_input_vec(vec2),
      .o_address(addr2), .i_weights(w2), .o_out_valid(v2), .o_out_index(idx2),
      .o_out_value(val2), .o_busy(busy2), .o_done(done2));

   always @(posedge clk) begin
      w1 <= (addr1 < 7'd10) ? mem1[addr1[3:0]] : '0;
      w2 <= (addr2 == 7'd0) ? mem2 : '0;
   end

   logic        m_valid, m_done, m_busy;
   logic [6:0]  m_addr, m_index;
   logic [31:0] m_value;
   assign m_valid = sel ? v2 : v1;
   assign m_done  = sel ? done2 : done1;
   assign m_busy  = sel ? busy2 : busy1;
   assign m_addr  = sel ? addr2 : addr1;
   assign m_index = sel ? idx2 : idx1;
   assign m_value = sel ? val2 : val1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic run_rows(input int n, input bit noise, input string tag);
      int strobes;
      int done_cyc;
      int max_addr;
      strobes  = 0;
      done_cyc = -1;
      max_addr = 0;
      @(negedge clk);
      if (sel) start2 = 1'b1; else start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start2 = 1'b0;
      if (noise) vec1 = {32{$urandom()}};
      for (int cyc = 1; cyc <= 34 * n + 3; cyc++) begin
         @(negedge clk);
         if (m_valid) begin
            chk($sformatf("%s valid_cycle[%0d]", tag, strobes), 32'(cyc), 32'(34 * (strobes + 1)));
            chk($sformatf("%s index[%0d]", tag, strobes), {25'd0, m_index}, 32'(strobes));
            chk($sformatf("%s value[%0d]", tag, strobes), m_value, exp_v[(strobes < 10) ? strobes : 9]);
            chk($sformatf("%s address[%0d]", tag, strobes), {25'd0, m_addr}, 32'(strobes));
            strobes++;
         end
         if (m_done) done_cyc = cyc;
         if (int'(m_addr) > max_addr) max_addr = int'(m_addr);
         if (noise) start1 = (cyc == 5 || cyc == 100);
         @(posedge clk);
      end
      @(negedge clk);
      chk($sformatf("%s strobe_count", tag), 32'(strobes), 32'(n));
      chk($sformatf("%s done_cycle", tag), 32'(done_cyc), 32'(34 * n + 1));
      chk($sformatf("%s max_address", tag), 32'(max_addr), 32'(n - 1));
      chk($sformatf("%s busy_after", tag), {31'd0, m_busy}, 32'd0);
   endtask

   task automatic load_ramp();
      logic [31:0] wv;
      vec1 = {32{32'h0001_0000}};
      for (int r = 0; r < 10; r++) begin
         wv       = 32'((r + 1) * 65536);
         mem1[r]  = {32{wv}};
         exp_v[r] = 32'((r + 1) * 32'h0020_0000);
      end
   endtask

   initial begin
      reset1 = 1'b1; reset2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
      vec1 = '0; vec2 = '0; mem2 = '0;
      for (int r = 0; r < 10; r++) mem1[r] = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      reset1 = 1'b0;
      reset2 = 1'b0;
      chk("rst out_valid", {31'd0, v1}, 32'd0);
      chk("rst out_index", {25'd0, idx1}, 32'd0);
      chk("rst out_value", val1, 32'd0);
      chk("rst busy", {31'd0, busy1}, 32'd0);
      chk("rst done", {31'd0, done1}, 32'd0);
      chk("rst address", {25'd0, addr1}, 32'd0);
      chk("rst2 busy", {31'd0, busy2}, 32'd0);

      // Ramp rows, with stray start pulses and input_vec scribbled after acceptance.
      load_ramp();
      run_rows(10, 1'b1, "ramp");

      // Saturation both ways, started straight after the previous done.
      vec1 = {32{32'h7FFF_FFFF}};
      for (int r = 0; r < 10; r++) begin
         mem1[r]  = (r % 2 == 0) ? {32{32'h7FFF_FFFF}} : {32{32'h8000_0000}};
         exp_v[r] = (r % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      end
      run_rows(10, 1'b0, "sat");

      // Single negative element; other weights are random but multiplied by zero.
      vec1 = '0;
      vec1[31:0] = 32'hFFFF_0000;
      for (int r = 0; r < 10; r++) begin
         for (int j = 1; j < 32; j++) mem1[r][32*j +: 32] = $urandom();
         mem1[r][31:0] = 32'((r + 1) * 65536);
         exp_v[r]      = 32'(-(r + 1) * 65536);
      end
      chk("neg row2 expectation", exp_v[2], 32'hFFFD_0000);
      run_rows(10, 1'b0, "neg");

      // Reset (with simultaneous start) during MAC of row 3.
      load_ramp();
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      for (int c = 1; c < 110; c++) @(posedge clk);
      @(negedge clk);
      reset1 = 1'b1;
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset1 = 1'b0;
      start1 = 1'b0;
      chk("abort busy", {31'd0, busy1}, 32'd0);
      chk("abort out_valid", {31'd0, v1}, 32'd0);
      chk("abort done", {31'd0, done1}, 32'd0);
      chk("abort address", {25'd0, addr1}, 32'd0);
      begin
         int seen_v;
         int seen_d;
         seen_v = 0;
         seen_d = 0;
         for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (v1) seen_v++;
            if (done1) seen_d++;
         end
         chk("abort no out_valid", 32'(seen_v), 32'd0);
         chk("abort no done", 32'(seen_d), 32'd0);
         chk("abort still idle", {31'd0, busy1}, 32'd0);
      end
      run_rows(10, 1'b0, "restart");

      // NUM_ROWS=1 instance.
      sel      = 1'b1;
      vec2     = {32{32'h0001_0000}};
      mem2     = {32{32'h0002_0000}};
      exp_v[0] = 32'h0040_0000;
      run_rows(1, 1'b0, "single");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
